sdram_arbit: RTL and testbench

//  Sequences shared SDRAM command/address/DQ bus among init, auto-refresh, write and read sub-blocks.

---
 rtl/sdram_pkg.sv | 26 ++
 rtl/sdram_arbit_grant.sv | 33 +++
 rtl/sdram_arbit.sv | 123 ++++++++++++
 tb/tb_sdram_arbit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM bus arbiter: FSM states, grant codes, SDRAM commands.
package sdram_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_AREF = 2'd1;
    localparam logic [1:0] GNT_WR   = 2'd2;
    localparam logic [1:0] GNT_RD   = 2'd3;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

endpackage

// File: rtl/sdram_arbit_grant.sv
// Combinational next-grant: refresh first, then write over read.
// With SDRAM_ARBIT_RR_EN defined, a simultaneous write/read request goes to whichever was not granted last.
module sdram_arbit_grant
    import sdram_pkg::*;
(
    input  logic       aref_req,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic       last_rd,
    output logic [1:0] gnt
);

`ifndef SDRAM_ARBIT_RR_EN
    logic unused_last_rd;
    assign unused_last_rd = last_rd;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (aref_req) begin
            gnt = GNT_AREF;
`ifdef SDRAM_ARBIT_RR_EN
        end else if (wr_req && rd_req) begin
            gnt = last_rd ? GNT_WR : GNT_RD;
`endif
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else if (rd_req) begin
            gnt = GNT_RD;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM pin arbiter: passes init sequence through, then grants the bus to refresh/write/read one at a time.
// Optional SDRAM_ARBIT_RR_EN: round-robin between simultaneous write and read requests.
module sdram_arbit #(
    parameter int         DATA_W  = 16,
    parameter int         ADDR_W  = 13,
    parameter int         BA_W    = 2,
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_sdram_addr,
    input  logic              wr_sdram_en,
    input  logic [DATA_W-1:0] wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] rd_sdram_data,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq
);
    import sdram_pkg::*;

    state_t     state, state_nxt;
    logic       last_rd;
    logic [1:0] gnt;
    logic [3:0] cmd;

    sdram_arbit_grant u_grant (
        .aref_req (aref_req),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .last_rd  (last_rd),
        .gnt      (gnt)
    );

    // last_rd resets high so the first write/read tie goes to write.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= ST_INIT;
            last_rd <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == ST_ARBIT && gnt == GNT_WR)
                last_rd <= 1'b0;
            else if (state == ST_ARBIT && gnt == GNT_RD)
                last_rd <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (init_end) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
                case (gnt)
                    GNT_AREF: state_nxt = ST_AREF;
                    GNT_WR:   state_nxt = ST_WRITE;
                    GNT_RD:   state_nxt = ST_READ;
                    default:  state_nxt = ST_ARBIT;
                endcase
            end
            ST_AREF:  if (aref_end) state_nxt = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_nxt = ST_ARBIT;
            ST_READ:  if (rd_end)   state_nxt = ST_ARBIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Pins follow the current owner combinationally; idle bus is NOP with all-ones address.
    always_comb begin
        cmd        = CMD_NOP;
        sdram_ba   = '1;
        sdram_addr = '1;
        case (state)
            ST_INIT: begin
                cmd = init_cmd; sdram_ba = init_ba; sdram_addr = init_addr;
            end
            ST_AREF: begin
                cmd = aref_cmd; sdram_ba = aref_ba; sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                cmd = wr_cmd; sdram_ba = wr_ba; sdram_addr = wr_sdram_addr;
            end
            ST_READ: begin
                cmd = rd_cmd; sdram_ba = rd_ba; sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign aref_en       = (state == ST_AREF);
    assign wr_en         = (state == ST_WRITE);
    assign rd_en         = (state == ST_READ);
    assign sdram_cke     = 1'b1;
    assign sdram_dq      = (state == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};
    assign rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized scoreboard bench for sdram_arbit: a bus-ownership model predicts pins and grants each cycle.
module tb_sdram_arbit;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
    logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
    logic [12:0] init_addr, aref_addr, wr_sdram_addr, rd_addr;
    logic [15:0] wr_sdram_data;
    logic        aref_en, wr_en, rd_en, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] rd_sdram_data;
    wire  [15:0] sdram_dq;

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_sdram_addr(wr_sdram_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .rd_sdram_data(rd_sdram_data),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
    );

    always #5 sys_clk = ~sys_clk;

`ifdef SDRAM_ARBIT_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Bus owner in the model
    localparam int O_INIT = 0, O_IDLE = 1, O_AREF = 2, O_WR = 3, O_RD = 4;

    typedef struct {
        logic [22:0] ctl;     // {aref_en, wr_en, rd_en, cke, cmd, ba, addr}
        logic        dq_chk;
        logic [15:0] dq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   owner;
    bit   last_was_rd;
    int   grant_log[$];

    function automatic logic [22:0] exp_ctl(int own);
        logic [3:0]  c = 4'b0111;
        logic [1:0]  b = 2'b11;
        logic [12:0] a = 13'h1fff;
        case (own)
            O_INIT: begin c = init_cmd; b = init_ba; a = init_addr; end
            O_AREF: begin c = aref_cmd; b = aref_ba; a = aref_addr; end
            O_WR:   begin c = wr_cmd;   b = wr_ba;   a = wr_sdram_addr; end
            O_RD:   begin c = rd_cmd;   b = rd_ba;   a = rd_addr; end
            default: ;
        endcase
        return {own == O_AREF, own == O_WR, own == O_RD, 1'b1, c, b, a};
    endfunction

    // Spec rules for who owns the bus after this edge.
    function automatic int next_owner(int own);
        if (sys_rst) return O_INIT;
        case (own)
            O_INIT: return init_end ? O_IDLE : O_INIT;
            O_IDLE: begin
                if (aref_req) return O_AREF;
                if (wr_req && rd_req && RR) return last_was_rd ? O_WR : O_RD;
                if (wr_req) return O_WR;
                if (rd_req) return O_RD;
                return O_IDLE;
            end
            O_AREF: return aref_end ? O_IDLE : O_AREF;
            O_WR:   return wr_end ? O_IDLE : O_WR;
            default: return rd_end ? O_IDLE : O_RD;
        endcase
    endfunction

    task automatic randomize_inputs(int mode);
        init_cmd  = 4'($urandom); init_ba  = 2'($urandom); init_addr     = 13'($urandom);
        aref_cmd  = 4'($urandom); aref_ba  = 2'($urandom); aref_addr     = 13'($urandom);
        wr_cmd    = 4'($urandom); wr_ba    = 2'($urandom); wr_sdram_addr = 13'($urandom);
        rd_cmd    = 4'($urandom); rd_ba    = 2'($urandom); rd_addr       = 13'($urandom);
        wr_sdram_data = 16'($urandom);
        wr_sdram_en   = 1'($urandom);
        init_end = ($urandom_range(0, 3) == 0);
        aref_end = ($urandom_range(0, 3) == 0);
        wr_end   = ($urandom_range(0, 3) == 0);
        rd_end   = ($urandom_range(0, 3) == 0);
        case (mode)
            0: begin
                aref_req = ($urandom_range(0, 7) == 0);
                wr_req   = ($urandom_range(0, 2) == 0);
                rd_req   = ($urandom_range(0, 2) == 0);
                sys_rst  = ($urandom_range(0, 63) == 0);
            end
            1: begin
                aref_req = 1'b0; wr_req = 1'b1; rd_req = 1'b1; sys_rst = 1'b0;
            end
            default: begin
                aref_req = ($urandom_range(0, 1) == 0);
                wr_req   = 1'b1; rd_req = 1'b1; sys_rst = 1'b0;
            end
        endcase
    endtask

    // One cycle: drive inputs, push this cycle's expected outputs, advance the model at the edge.
    task automatic drive_cycle(int mode);
        exp_t e;
        int   nxt;
        randomize_inputs(mode);
        e.ctl    = exp_ctl(owner);
        e.dq_chk = (owner == O_WR) && wr_sdram_en;
        e.dq     = wr_sdram_data;
        q.push_back(e);
        nxt = next_owner(owner);
        if (sys_rst) last_was_rd = 1'b1;
        else if (owner == O_IDLE && nxt == O_WR) last_was_rd = 1'b0;
        else if (owner == O_IDLE && nxt == O_RD) last_was_rd = 1'b1;
        if (owner == O_IDLE && (nxt == O_WR || nxt == O_RD)) grant_log.push_back(nxt);
        @(posedge sys_clk);
        owner = nxt;
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [22:0] act;
        forever begin
            @(negedge sys_clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {aref_en, wr_en, rd_en, sdram_cke,
                       sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr};
                checks++;
                if (act !== e.ctl) begin
                    failures++;
                    $display("FAIL pins/grant t=%0t actual=%h required=%h", $time, act, e.ctl);
                end
                if (e.dq_chk) begin
                    checks++;
                    if (rd_sdram_data !== e.dq) begin
                        failures++;
                        $display("FAIL dq t=%0t actual=%h required=%h", $time, rd_sdram_data, e.dq);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cyc;
        randomize_inputs(1);
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        owner       = O_INIT;
        last_was_rd = 1'b1;
        sys_rst     = 1'b0;

        // Directed opening: reset state, then init_end -> idle NOP bus, then a write grant.
        randomize_inputs(0);
        begin
            exp_t e;
            e.ctl = exp_ctl(O_INIT); e.dq_chk = 1'b0; e.dq = '0;
            q.push_back(e);
        end
        sys_rst = 1'b0; init_end = 1'b1; aref_req = 1'b0; wr_req = 1'b1; rd_req = 1'b0;
        @(posedge sys_clk); #1;
        owner = O_IDLE;
        init_end = 1'b0;
        begin
            exp_t e;
            e.ctl = {3'b000, 1'b1, 4'b0111, 2'b11, 13'h1fff}; e.dq_chk = 1'b0; e.dq = '0;
            q.push_back(e);
        end
        @(posedge sys_clk); #1;
        owner       = O_WR;
        last_was_rd = 1'b0;
        grant_log.push_back(O_WR);

        for (int blk = 0; blk < 9; blk++)
            for (int c = 0; c < 200; c++)
                drive_cycle(blk % 3);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge sys_clk);
            wait_cyc++;
        end
        checks++;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
